// File: rtl/vga_pkg.sv
// Shared VGA timing definitions.
// Provides per-axis timing sets (active, front porch, sync, back porch) for
// the common modes and a helper that sums an axis into its total period.
package vga_pkg;

   typedef struct packed {
      logic [15:0] active;
      logic [15:0] fp;
      logic [15:0] sync;
      logic [15:0] bp;
   } axis_timing_t;

   // 640x480 @ 60 Hz (25.175 MHz pixel clock)
   localparam axis_timing_t VGA_640X480_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48};
   localparam axis_timing_t VGA_640X480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33};

   // 800x600 @ 60 Hz (40 MHz pixel clock)
   localparam axis_timing_t VGA_800X600_H = '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88};
   localparam axis_timing_t VGA_800X600_V = '{active: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23};

   function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus next-state sync/active decode.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset (count -> TOTAL-1)
//   inc_i           : advance the position by one this clk
//   count_o         : current position, registered, 0..TOTAL-1
//   wrap_c_o        : inc_i while at TOTAL-1 (combinational carry to next axis)
//   sync_nxt_c_o    : sync level for the position taking effect at the next edge
//   active_nxt_c_o  : active-region flag for that same next position
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = 640,
   parameter int unsigned FP     = 16,
   parameter int unsigned SYNC   = 96,
   parameter int unsigned BP     = 48,
   parameter bit          POL    = 1'b0,
   parameter int unsigned W      = 10
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o,
   output logic         wrap_c_o,
   output logic         sync_nxt_c_o,
   output logic         active_nxt_c_o
);

   localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
   localparam int unsigned SYNC_START = ACTIVE + FP;
   localparam int unsigned SYNC_END   = SYNC_START + SYNC;

   if (TOTAL > (32'(1) << W)) begin : g_width_err
      $error("vga_axis_counter: axis total does not fit in W bits");
   end
   if (BP < 1) begin : g_bp_err
      $error("vga_axis_counter: back porch must be at least 1");
   end

   logic [W-1:0] count_q, count_d;

   // Next position and the decode of that position, so registered outputs
   // downstream line up with the count they accompany.
   always_comb begin
      count_d        = count_q;
      wrap_c_o       = inc_i && (count_q == W'(TOTAL - 1));
      if (wrap_c_o) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = count_q + W'(1);
      end
      sync_nxt_c_o   = ((count_d >= W'(SYNC_START)) && (count_d < W'(SYNC_END))) ? POL : ~POL;
      active_nxt_c_o = (count_d < W'(ACTIVE));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= W'(TOTAL - 1);
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock-enable divider.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   en           : run enable; low freezes all state and drops the strobes
//   pix_tick     : combinational, high in the clk the pixel position advances
//   x, y         : current raster position
//   hsync, vsync : sync outputs, active level set by HS_POL / VS_POL
//   video_on     : inside the visible area
//   line_start   : one-clk strobe on arriving at x == 0
//   frame_start  : one-clk strobe on arriving at (0, 0)
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 32'(VGA_640X480_H.active),
   parameter int unsigned H_FP     = 32'(VGA_640X480_H.fp),
   parameter int unsigned H_SYNC   = 32'(VGA_640X480_H.sync),
   parameter int unsigned H_BP     = 32'(VGA_640X480_H.bp),
   parameter int unsigned V_ACTIVE = 32'(VGA_640X480_V.active),
   parameter int unsigned V_FP     = 32'(VGA_640X480_V.fp),
   parameter int unsigned V_SYNC   = 32'(VGA_640X480_V.sync),
   parameter int unsigned V_BP     = 32'(VGA_640X480_V.bp),
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned PIX_DIV  = 1,
   parameter int unsigned H_W      = 10,
   parameter int unsigned V_W      = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   output logic           pix_tick,
   output logic [H_W-1:0] x,
   output logic [V_W-1:0] y,
   output logic           hsync,
   output logic           vsync,
   output logic           video_on,
   output logic           line_start,
   output logic           frame_start
);

   localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   if (PIX_DIV < 1) begin : g_div_err
      $error("vga_timing_gen: PIX_DIV must be at least 1");
   end

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             h_wrap, v_wrap;
   logic             h_sync_nxt, v_sync_nxt;
   logic             h_act_nxt, v_act_nxt;
   logic             hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

   // Pixel-rate enable; suppressed during reset so no advance leaks out.
   always_comb begin
      pix_tick  = ~rst & en & (div_cnt_q == DIV_W'(PIX_DIV - 1));
      div_cnt_d = div_cnt_q;
      if (en) begin
         div_cnt_d = pix_tick ? '0 : div_cnt_q + DIV_W'(1);
      end
   end

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(H_W)
   ) u_h (
      .clk_i         (clk),
      .rst_i         (rst),
      .inc_i         (pix_tick),
      .count_o       (x),
      .wrap_c_o      (h_wrap),
      .sync_nxt_c_o  (h_sync_nxt),
      .active_nxt_c_o(h_act_nxt)
   );

   // Vertical axis advances on the horizontal carry.
   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(V_W)
   ) u_v (
      .clk_i         (clk),
      .rst_i         (rst),
      .inc_i         (h_wrap),
      .count_o       (y),
      .wrap_c_o      (v_wrap),
      .sync_nxt_c_o  (v_sync_nxt),
      .active_nxt_c_o(v_act_nxt)
   );

   // Output registers fed from next-state decode: zero skew against x/y.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q     <= '0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (en) begin
         div_cnt_q     <= div_cnt_d;
         hsync_q       <= h_sync_nxt;
         vsync_q       <= v_sync_nxt;
         video_on_q    <= h_act_nxt & v_act_nxt;
         line_start_q  <= h_wrap;
         frame_start_q <= h_wrap & v_wrap;
      end else begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three configurations share rst/en.
// The reference model tracks only the number of enabled clocks since reset
// and derives the raster position and all outputs arithmetically from it.
module tb_vga_timing_gen;

   typedef struct packed {
      logic       tick;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       von;
      logic       ls;
      logic       fs;
   } obs_t;

   typedef struct {
      int h_act, h_fp, h_sync, h_bp;
      int v_act, v_fp, v_sync, v_bp;
      bit h_pol, v_pol;
      int div;
   } cfg_t;

   localparam int NI     = 3;
   localparam int N_CYC  = 9000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en;

   logic       a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
   logic [9:0] a_x, a_y;
   logic       b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
   logic [3:0] b_x, b_y;
   logic       c_tick, c_hs, c_vs, c_von, c_ls, c_fs;
   logic [3:0] c_x;
   logic [2:0] c_y;

   // 640x480 defaults
   vga_timing_gen dut_a (
      .clk(clk), .rst(rst), .en(en), .pix_tick(a_tick), .x(a_x), .y(a_y),
      .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .line_start(a_ls), .frame_start(a_fs)
   );

   // small raster, divide by 3, mixed polarity
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b0), .PIX_DIV(3), .H_W(4), .V_W(4)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en), .pix_tick(b_tick), .x(b_x), .y(b_y),
      .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .line_start(b_ls), .frame_start(b_fs)
   );

   // small raster, divide by 4, both active-high, tight counter widths
   vga_timing_gen #(
      .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(4), .H_W(4), .V_W(3)
   ) dut_c (
      .clk(clk), .rst(rst), .en(en), .pix_tick(c_tick), .x(c_x), .y(c_y),
      .hsync(c_hs), .vsync(c_vs), .video_on(c_von), .line_start(c_ls), .frame_start(c_fs)
   );

   obs_t dut_obs [NI];
   assign dut_obs[0] = {a_tick, a_x, a_y, a_hs, a_vs, a_von, a_ls, a_fs};
   assign dut_obs[1] = {b_tick, 10'(b_x), 10'(b_y), b_hs, b_vs, b_von, b_ls, b_fs};
   assign dut_obs[2] = {c_tick, 10'(c_x), 10'(c_y), c_hs, c_vs, c_von, c_ls, c_fs};

   cfg_t    cfg  [NI];
   longint  e_m  [NI];
   bit      ls_m [NI];
   bit      fs_m [NI];
   obs_t    sb   [NI][$];

   int tests = 0;
   int fails = 0;
   bit stim_done = 1'b0;

   function automatic int h_total(cfg_t c);
      return c.h_act + c.h_fp + c.h_sync + c.h_bp;
   endfunction

   function automatic int v_total(cfg_t c);
      return c.v_act + c.v_fp + c.v_sync + c.v_bp;
   endfunction

   // Linear raster index: one step per PIX_DIV enabled clocks, starting one
   // step before (0,0) so the first pixel advance lands on the origin.
   function automatic longint pos_of(cfg_t c, longint e);
      longint f;
      f = longint'(h_total(c)) * longint'(v_total(c));
      return (e / c.div + f - 1) % f;
   endfunction

   function automatic obs_t predict(cfg_t c, longint e, bit ls, bit fs, bit r, bit n);
      obs_t   o;
      longint p;
      int     px, py;
      p  = pos_of(c, e);
      px = int'(p % h_total(c));
      py = int'(p / h_total(c));
      o.tick = !r && n && (((e + 1) % c.div) == 0);
      o.x    = 10'(px);
      o.y    = 10'(py);
      o.hs   = (px >= c.h_act + c.h_fp && px < c.h_act + c.h_fp + c.h_sync) ? c.h_pol : !c.h_pol;
      o.vs   = (py >= c.v_act + c.v_fp && py < c.v_act + c.v_fp + c.v_sync) ? c.v_pol : !c.v_pol;
      o.von  = (px < c.h_act) && (py < c.v_act);
      o.ls   = ls;
      o.fs   = fs;
      return o;
   endfunction

   task automatic model_step(int i, bit r, bit n);
      bit     tick;
      longint p;
      if (r) begin
         e_m[i]  = 0;
         ls_m[i] = 1'b0;
         fs_m[i] = 1'b0;
      end else if (n) begin
         tick    = (((e_m[i] + 1) % cfg[i].div) == 0);
         e_m[i]  = e_m[i] + 1;
         p       = pos_of(cfg[i], e_m[i]);
         ls_m[i] = tick && ((p % h_total(cfg[i])) == 0);
         fs_m[i] = tick && (p == 0);
      end else begin
         ls_m[i] = 1'b0;
         fs_m[i] = 1'b0;
      end
   endtask

   // Stimulus: directed run with an enable gap and a reset, then random.
   initial begin
      bit r_prev, n_prev, r_new, n_new;
      cfg[0] = '{h_act:640, h_fp:16, h_sync:96, h_bp:48, v_act:480, v_fp:10, v_sync:2, v_bp:33,
                 h_pol:1'b0, v_pol:1'b0, div:1};
      cfg[1] = '{h_act:8, h_fp:2, h_sync:3, h_bp:2, v_act:5, v_fp:1, v_sync:2, v_bp:1,
                 h_pol:1'b1, v_pol:1'b0, div:3};
      cfg[2] = '{h_act:6, h_fp:1, h_sync:2, h_bp:1, v_act:4, v_fp:1, v_sync:1, v_bp:1,
                 h_pol:1'b1, v_pol:1'b1, div:4};
      for (int i = 0; i < NI; i++) begin
         e_m[i] = 0; ls_m[i] = 1'b0; fs_m[i] = 1'b0;
      end
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      r_prev = 1'b1;
      n_prev = 1'b0;
      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++) model_step(i, r_prev, n_prev);
         if (cyc < 2500) begin
            r_new = (cyc == 2000);
            n_new = !(cyc >= 300 && cyc < 310);
         end else begin
            r_new = ($urandom_range(0, 499) == 0);
            n_new = ($urandom_range(0, 7) != 0);
         end
         rst = r_new;
         en  = n_new;
         for (int i = 0; i < NI; i++)
            sb[i].push_back(predict(cfg[i], e_m[i], ls_m[i], fs_m[i], r_new, n_new));
         r_prev = r_new;
         n_prev = n_new;
      end
      @(negedge clk);
      #1;
      stim_done = 1'b1;
   end

   // Monitor: every clk each DUT presents a full output vector.
   initial begin
      obs_t exp_o;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (sb[i].size() > 0) begin
               exp_o = sb[i].pop_front();
               tests++;
               if (dut_obs[i] !== exp_o) begin
                  fails++;
                  $display("FAIL dut%0d outputs t=%0t got tick=%b x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b required tick=%b x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
                           i, $time,
                           dut_obs[i].tick, dut_obs[i].x, dut_obs[i].y, dut_obs[i].hs, dut_obs[i].vs,
                           dut_obs[i].von, dut_obs[i].ls, dut_obs[i].fs,
                           exp_o.tick, exp_o.x, exp_o.y, exp_o.hs, exp_o.vs, exp_o.von, exp_o.ls, exp_o.fs);
               end
            end
         end
      end
   end

   // Drain check, summary and a hard time bound.
   initial begin
      fork
         begin
            wait (stim_done);
         end
         begin
            repeat (N_CYC + 200) @(posedge clk);
         end
      join_any
      disable fork;
      for (int i = 0; i < NI; i++) begin
         tests++;
         if (!stim_done || sb[i].size() != 0) begin
            fails++;
            $display("FAIL dut%0d scoreboard_drain got %0d pending (done=%b) required 0 pending",
                     i, sb[i].size(), stim_done);
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
